// File: rtl/dimm_cmd_sched_if.sv
// Request, command and status bundle between the request front end and the DDR5 command scheduler.
interface dimm_cmd_sched_if #(parameter int DEPTH = 16);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [35:0]   req_addr;
  logic          cmd_valid;
  logic [1:0]    cmd_type;
  logic [2:0]    cmd_bg;
  logic [1:0]    cmd_bank;
  logic [15:0]   cmd_row;
  logic [9:0]    cmd_col;
  logic          done_valid;
  logic          rd_data_valid;
  logic          err_illegal;
  logic [CW-1:0] q_count;
  logic          q_full;
  logic          q_empty;

  modport master (
    output req_valid, req_op, req_addr,
    input  req_ready, cmd_valid, cmd_type, cmd_bg, cmd_bank, cmd_row, cmd_col,
    input  done_valid, rd_data_valid, err_illegal, q_count, q_full, q_empty
  );

  modport slave (
    input  req_valid, req_op, req_addr,
    output req_ready, cmd_valid, cmd_type, cmd_bg, cmd_bank, cmd_row, cmd_col,
    output done_valid, rd_data_valid, err_illegal, q_count, q_full, q_empty
  );
endinterface

// File: rtl/dimm_cmd_sched.sv
// DDR5 single-channel command scheduler: in-order request queue, per-bank row tracking,
// ACT/RD/WR/PRE issue with tRP/tRCD/tRTP/tWR/tCCD spacing and open- or closed-page policy.
module dimm_cmd_sched #(
  parameter int DEPTH     = 16,
  parameter int OPEN_PAGE = 0,
  parameter int CHANNEL   = 0,
  parameter int T_RP      = 10,
  parameter int T_RCD     = 8,
  parameter int T_CL      = 6,
  parameter int T_BURST   = 4,
  parameter int T_RTP     = 2,
  parameter int T_WR      = 10,
  parameter int T_CWL     = 8
) (
  input logic            clk,
  input logic            rst_n,
  dimm_cmd_sched_if.slave bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int NB    = 32;
  localparam int CNT_W = 7;
  localparam int RL    = T_CL + T_BURST;

  // Counters hold N-1 after the issuing edge so the dependent command lands exactly N cycles later.
  localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] LD_RCD = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] LD_CCD = CNT_W'(T_BURST - 1);
  localparam logic [CNT_W-1:0] LD_RTP = CNT_W'(T_RTP - 1);
  localparam logic [CNT_W-1:0] LD_WRP = CNT_W'(T_CWL + T_BURST + T_WR - 1);

  localparam logic [1:0] C_ACT = 2'd0;
  localparam logic [1:0] C_RD  = 2'd1;
  localparam logic [1:0] C_WR  = 2'd2;
  localparam logic [1:0] C_PRE = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ACT, S_COL, S_CLOSE} state_t;

  function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] c);
    return (c == '0) ? '0 : c - CNT_W'(1);
  endfunction

  state_t           state;
  logic [1:0]       q_op  [DEPTH];
  logic [15:0]      q_row [DEPTH];
  logic [9:0]       q_col [DEPTH];
  logic [4:0]       q_bnk [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_nxt;
  logic             full_r, empty_r, err_r;
  logic             accept, legal, push, pop;

  logic [NB-1:0]    open_r;
  logic [15:0]      row_r   [NB];
  logic [CNT_W-1:0] act_cnt [NB];
  logic [CNT_W-1:0] rcd_cnt [NB];
  logic [CNT_W-1:0] pre_cnt [NB];
  logic [CNT_W-1:0] ccd_cnt;

  logic [1:0]       cur_op;
  logic [4:0]       cur_b;
  logic [15:0]      cur_row;
  logic [9:0]       cur_col;
  logic [RL-1:0]    rd_sr;

  logic             go, col_go, rd_go;
  logic [1:0]       ctype;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{bus.req_addr[35:34], bus.req_addr[1:0]};

  assign accept    = bus.req_valid && !full_r;
  assign legal     = (bus.req_op != 2'd3) && (bus.req_addr[6] == 1'(CHANNEL));
  assign push      = accept && legal;
  assign pop       = col_go;
  assign count_nxt = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      q_op[wr_ptr]  <= bus.req_op;
      q_row[wr_ptr] <= bus.req_addr[33:18];
      q_col[wr_ptr] <= {bus.req_addr[17:12], bus.req_addr[5:2]};
      q_bnk[wr_ptr] <= {bus.req_addr[9:7], bus.req_addr[11:10]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      err_r   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count   <= count_nxt;
      full_r  <= (count_nxt == CW'(DEPTH));
      empty_r <= (count_nxt == '0);
      err_r   <= accept && !legal;
    end
  end

  // Command issue is decided combinationally from the state and the target bank's counters.
  always_comb begin
    go    = 1'b0;
    ctype = C_ACT;
    unique case (state)
      S_PRE, S_CLOSE: begin
        go    = (pre_cnt[cur_b] == '0);
        ctype = C_PRE;
      end
      S_ACT: begin
        go    = (act_cnt[cur_b] == '0);
        ctype = C_ACT;
      end
      S_COL: begin
        go    = (rcd_cnt[cur_b] == '0) && (ccd_cnt == '0);
        ctype = (cur_op == 2'd1) ? C_WR : C_RD;
      end
      default: begin
        go    = 1'b0;
        ctype = C_ACT;
      end
    endcase
  end

  assign col_go = go && (state == S_COL);
  assign rd_go  = col_go && (cur_op != 2'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      open_r  <= '0;
      ccd_cnt <= '0;
      rd_sr   <= '0;
      for (int b = 0; b < NB; b++) begin
        act_cnt[b] <= '0;
        rcd_cnt[b] <= '0;
        pre_cnt[b] <= '0;
      end
    end else begin
      ccd_cnt <= dec_sat(ccd_cnt);
      rd_sr   <= {rd_sr[RL-2:0], rd_go};
      for (int b = 0; b < NB; b++) begin
        act_cnt[b] <= dec_sat(act_cnt[b]);
        rcd_cnt[b] <= dec_sat(rcd_cnt[b]);
        pre_cnt[b] <= dec_sat(pre_cnt[b]);
      end
      unique case (state)
        S_IDLE: begin
          if (!empty_r) begin
            cur_op  <= q_op[rd_ptr];
            cur_b   <= q_bnk[rd_ptr];
            cur_row <= q_row[rd_ptr];
            cur_col <= q_col[rd_ptr];
            if ((OPEN_PAGE != 0) && open_r[q_bnk[rd_ptr]])
              state <= (row_r[q_bnk[rd_ptr]] == q_row[rd_ptr]) ? S_COL : S_PRE;
            else
              state <= S_ACT;
          end
        end
        S_PRE: begin
          if (go) begin
            open_r[cur_b]  <= 1'b0;
            act_cnt[cur_b] <= LD_RP;
            state          <= S_ACT;
          end
        end
        S_ACT: begin
          if (go) begin
            open_r[cur_b]  <= 1'b1;
            row_r[cur_b]   <= cur_row;
            rcd_cnt[cur_b] <= LD_RCD;
            state          <= S_COL;
          end
        end
        S_COL: begin
          if (go) begin
            ccd_cnt        <= LD_CCD;
            pre_cnt[cur_b] <= (cur_op == 2'd1) ? LD_WRP : LD_RTP;
            state          <= (OPEN_PAGE != 0) ? S_IDLE : S_CLOSE;
          end
        end
        S_CLOSE: begin
          if (go) begin
            open_r[cur_b]  <= 1'b0;
            act_cnt[cur_b] <= LD_RP;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready     = !full_r;
  assign bus.cmd_valid     = go;
  assign bus.cmd_type      = go ? ctype : 2'd0;
  assign bus.cmd_bg        = go ? cur_b[4:2] : 3'd0;
  assign bus.cmd_bank      = go ? cur_b[1:0] : 2'd0;
  assign bus.cmd_row       = go ? cur_row : 16'd0;
  assign bus.cmd_col       = col_go ? cur_col : 10'd0;
  assign bus.done_valid    = col_go;
  assign bus.rd_data_valid = rd_sr[RL-1];
  assign bus.err_illegal   = err_r;
  assign bus.q_count       = count;
  assign bus.q_full        = full_r;
  assign bus.q_empty       = empty_r;

endmodule

// File: tb/tb_dimm_cmd_sched.sv
// Directed bench for dimm_cmd_sched: a closed-page and an open-page instance share clock and reset.
module tb_dimm_cmd_sched;

  localparam int ACT = 0;
  localparam int RD  = 1;
  localparam int WR  = 2;
  localparam int PRE = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dimm_cmd_sched_if #(.DEPTH(16)) ba ();
  dimm_cmd_sched_if #(.DEPTH(16)) bb ();

  dimm_cmd_sched #(.DEPTH(16), .OPEN_PAGE(0), .CHANNEL(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ba));
  dimm_cmd_sched #(.DEPTH(16), .OPEN_PAGE(1), .CHANNEL(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bb));

  int ntests = 0;
  int nfail  = 0;
  int rel;
  int a_cyc[$], a_typ[$], a_row[$], a_col[$], a_bg[$], a_bank[$], a_done[$], a_rdv[$];
  int b_cyc[$], b_typ[$], b_done[$], b_rdv[$];
  logic a_qe  [0:63];
  logic a_err [0:63];
  int   a_qc  [0:63];
  int   a_full_cycles, a_full_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int qg(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [35:0] mk_addr(input logic [15:0] row, input logic [2:0] bg,
                                          input logic [1:0] bank, input logic [9:0] col, input logic ch);
    logic [35:0] a;
    a = '0;
    a[33:18] = row;
    a[17:12] = col[9:4];
    a[11:10] = bank;
    a[9:7]   = bg;
    a[6]     = ch;
    a[5:2]   = col[3:0];
    return a;
  endfunction

  // One cycle: sample everything at the falling edge, logged against the test-relative cycle.
  task automatic tick();
    @(negedge clk);
    rel++;
    if (ba.cmd_valid) begin
      a_cyc.push_back(rel);  a_typ.push_back(int'(ba.cmd_type));
      a_row.push_back(int'(ba.cmd_row)); a_col.push_back(int'(ba.cmd_col));
      a_bg.push_back(int'(ba.cmd_bg));   a_bank.push_back(int'(ba.cmd_bank));
    end
    if (ba.done_valid)    a_done.push_back(rel);
    if (ba.rd_data_valid) a_rdv.push_back(rel);
    if (bb.cmd_valid) begin
      b_cyc.push_back(rel); b_typ.push_back(int'(bb.cmd_type));
    end
    if (bb.done_valid)    b_done.push_back(rel);
    if (bb.rd_data_valid) b_rdv.push_back(rel);
    if (rel >= 0 && rel < 64) begin
      a_qe[rel]  = ba.q_empty;
      a_err[rel] = ba.err_illegal;
      a_qc[rel]  = int'(ba.q_count);
    end
    if (ba.q_full) begin
      a_full_cycles++;
      if (ba.req_ready) a_full_ready++;
    end
  endtask

  task automatic clear();
    a_cyc.delete(); a_typ.delete(); a_row.delete(); a_col.delete();
    a_bg.delete(); a_bank.delete(); a_done.delete(); a_rdv.delete();
    b_cyc.delete(); b_typ.delete(); b_done.delete(); b_rdv.delete();
    a_full_cycles = 0;
    a_full_ready  = 0;
    rel = -1;
  endtask

  task automatic drv_a(input logic v, input logic [1:0] op, input logic [35:0] addr);
    ba.req_valid = v; ba.req_op = op; ba.req_addr = addr;
  endtask

  task automatic drv_b(input logic v, input logic [1:0] op, input logic [35:0] addr);
    bb.req_valid = v; bb.req_op = op; bb.req_addr = addr;
  endtask

  task automatic chk_a(input string tag, input int i, input int ec, input int et);
    chk({tag, "_cyc"}, qg(a_cyc, i), ec);
    chk({tag, "_type"}, qg(a_typ, i), et);
  endtask

  task automatic chk_b(input string tag, input int i, input int ec, input int et);
    chk({tag, "_cyc"}, qg(b_cyc, i), ec);
    chk({tag, "_type"}, qg(b_typ, i), et);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, k, n_before, timeouts;
    logic acc, ok;

    rst_n = 1'b0;
    drv_a(1'b0, 2'd0, '0);
    drv_b(1'b0, 2'd0, '0);
    clear();
    repeat (3) tick();
    chk("rst_req_ready", ba.req_ready, 1);
    chk("rst_q_empty", ba.q_empty, 1);
    chk("rst_q_full", ba.q_full, 0);
    chk("rst_q_count", ba.q_count, 0);
    chk("rst_cmd_valid", ba.cmd_valid, 0);
    chk("rst_done", ba.done_valid, 0);
    chk("rst_rdv", ba.rd_data_valid, 0);
    chk("rst_err", ba.err_illegal, 0);
    chk("rst_b_cmd_valid", bb.cmd_valid, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Closed page, single read.
    clear(); tick();
    drv_a(1'b1, 2'd0, mk_addr(16'h1234, 3'd2, 2'd1, 10'h155, 1'b0));
    tick();
    drv_a(1'b0, 2'd0, '0);
    repeat (28) tick();
    chk("t1_ncmd", a_cyc.size(), 3);
    chk_a("t1_act", 0, 2, ACT);
    chk_a("t1_rd", 1, 10, RD);
    chk_a("t1_pre", 2, 12, PRE);
    chk("t1_act_row", qg(a_row, 0), 16'h1234);
    chk("t1_act_bg", qg(a_bg, 0), 2);
    chk("t1_act_bank", qg(a_bank, 0), 1);
    chk("t1_rd_col", qg(a_col, 1), 10'h155);
    chk("t1_ndone", a_done.size(), 1);
    chk("t1_done_cyc", qg(a_done, 0), 10);
    chk("t1_nrdv", a_rdv.size(), 1);
    chk("t1_rdv_cyc", qg(a_rdv, 0), 20);
    chk("t1_qempty_10", a_qe[10], 0);
    chk("t1_qempty_11", a_qe[11], 1);

    // Closed page, write then read to the same bank.
    clear(); tick();
    drv_a(1'b1, 2'd1, mk_addr(16'h0100, 3'd5, 2'd3, 10'h001, 1'b0));
    tick();
    drv_a(1'b1, 2'd0, mk_addr(16'h0200, 3'd5, 2'd3, 10'h002, 1'b0));
    tick();
    drv_a(1'b0, 2'd0, '0);
    repeat (60) tick();
    chk("t2_ncmd", a_cyc.size(), 6);
    chk_a("t2_act0", 0, 2, ACT);
    chk_a("t2_wr", 1, 10, WR);
    chk_a("t2_pre0", 2, 32, PRE);
    chk_a("t2_act1", 3, 42, ACT);
    chk_a("t2_rd", 4, 50, RD);
    chk_a("t2_pre1", 5, 52, PRE);
    chk("t2_nrdv", a_rdv.size(), 1);
    chk("t2_rdv_cyc", qg(a_rdv, 0), 60);

    // Open page, two reads to the same row.
    clear(); tick();
    drv_b(1'b1, 2'd0, mk_addr(16'h0AAA, 3'd1, 2'd0, 10'h010, 1'b0));
    tick();
    drv_b(1'b1, 2'd2, mk_addr(16'h0AAA, 3'd1, 2'd0, 10'h020, 1'b0));
    tick();
    drv_b(1'b0, 2'd0, '0);
    repeat (40) tick();
    chk("t3_ncmd", b_cyc.size(), 3);
    chk_b("t3_act", 0, 2, ACT);
    chk_b("t3_rd0", 1, 10, RD);
    chk_b("t3_rd1", 2, 14, RD);
    chk("t3_done1", qg(b_done, 1), 14);
    chk("t3_rdv0", qg(b_rdv, 0), 20);
    chk("t3_rdv1", qg(b_rdv, 1), 24);

    // Open page, row conflict in one bank.
    clear(); tick();
    drv_b(1'b1, 2'd0, mk_addr(16'h0001, 3'd1, 2'd2, 10'h000, 1'b0));
    tick();
    drv_b(1'b1, 2'd0, mk_addr(16'h0002, 3'd1, 2'd2, 10'h000, 1'b0));
    tick();
    drv_b(1'b0, 2'd0, '0);
    repeat (45) tick();
    chk("t4_ncmd", b_cyc.size(), 5);
    chk_b("t4_act0", 0, 2, ACT);
    chk_b("t4_rd0", 1, 10, RD);
    chk_b("t4_pre", 2, 12, PRE);
    chk_b("t4_act1", 3, 22, ACT);
    chk_b("t4_rd1", 4, 30, RD);

    // Closed page, 24 reads to one bank with distinct rows: queue fills.
    clear(); tick();
    timeouts = 0;
    for (int i = 0; i < 24; i++) begin
      drv_a(1'b1, 2'd0, mk_addr(16'(16'h0100 + i), 3'd0, 2'd0, 10'(i), 1'b0));
      ok = 1'b0;
      for (int w = 0; w < 700 && !ok; w++) begin
        acc = ba.req_ready;
        tick();
        if (acc) ok = 1'b1;
      end
      if (!ok) timeouts++;
    end
    drv_a(1'b0, 2'd0, '0);
    for (int w = 0; w < 700 && a_done.size() < 24; w++) tick();
    repeat (15) tick();
    chk("t5_push_timeouts", timeouts, 0);
    chk("t5_full_seen", (a_full_cycles > 0), 1);
    chk("t5_ready_while_full", a_full_ready, 0);
    chk("t5_ndone", a_done.size(), 24);
    chk("t5_nrdv", a_rdv.size(), 24);
    bad = 0;
    k = 0;
    for (int j = 0; j < a_typ.size(); j++) begin
      if (a_typ[j] == RD) begin
        if (a_row[j] != 16'h0100 + k || a_cyc[j] != 10 + 20 * k) bad++;
        k++;
      end
    end
    chk("t5_nrd", k, 24);
    chk("t5_order_timing_bad", bad, 0);
    chk("t5_qempty_end", ba.q_empty, 1);

    // Illegal requests: op 3, then wrong channel.
    clear(); tick();
    drv_a(1'b1, 2'd3, mk_addr(16'h0003, 3'd4, 2'd0, 10'h000, 1'b0));
    tick();
    drv_a(1'b0, 2'd0, '0);
    repeat (2) tick();
    drv_a(1'b1, 2'd0, mk_addr(16'h0004, 3'd4, 2'd0, 10'h000, 1'b1));
    tick();
    drv_a(1'b0, 2'd0, '0);
    repeat (12) tick();
    chk("t6_err_0", a_err[0], 0);
    chk("t6_err_1", a_err[1], 1);
    chk("t6_err_2", a_err[2], 0);
    chk("t6_qcount_1", a_qc[1], 0);
    chk("t6_err_4", a_err[4], 1);
    chk("t6_err_5", a_err[5], 0);
    chk("t6_qcount_5", a_qc[5], 0);
    chk("t6_ncmd", a_cyc.size(), 0);

    // Reset between ACT and RD.
    clear(); tick();
    drv_a(1'b1, 2'd0, mk_addr(16'h0777, 3'd3, 2'd2, 10'h000, 1'b0));
    tick();
    drv_a(1'b0, 2'd0, '0);
    repeat (4) tick();
    chk_a("t7_act", 0, 2, ACT);
    rst_n = 1'b0;
    tick();
    chk("t7_rst_cmd_valid", ba.cmd_valid, 0);
    chk("t7_rst_q_empty", ba.q_empty, 1);
    chk("t7_rst_q_count", ba.q_count, 0);
    chk("t7_rst_req_ready", ba.req_ready, 1);
    tick();
    rst_n = 1'b1;
    n_before = a_cyc.size();
    repeat (25) tick();
    chk("t7_cmds_after_rst", a_cyc.size() - n_before, 0);
    chk("t7_ndone", a_done.size(), 0);
    chk("t7_nrdv", a_rdv.size(), 0);

    // Fresh read after reset, then reset while its data return is pending.
    clear(); tick();
    drv_a(1'b1, 2'd0, mk_addr(16'h0777, 3'd3, 2'd2, 10'h000, 1'b0));
    tick();
    drv_a(1'b0, 2'd0, '0);
    repeat (12) tick();
    chk_a("t8_act", 0, 2, ACT);
    chk_a("t8_rd", 1, 10, RD);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("t8_nrdv_discarded", a_rdv.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
